logicnets_lut_layer: RTL and testbench
======================================

# logicnets_lut_layer

Runtime-programmable, pipelined LogicNets layer: `NUM_NEURONS` truth-table neurons, each mapping an `IN_BITS`-bit fan-in vector to an `OUT_BITS`-bit activation. It is the parametrised successor of the fixed per-neuron combinational ROMs. Tables are loaded over a configuration stream instead of being synthesised as constant case statements. The block sits between the quantised input/previous layer and the next layer in the quantum-readout network, with valid/ready streaming on both sides.

## Interface
Parameters:
- `NUM_NEURONS`, 4: neurons in the layer.
- `IN_BITS`, 7: per-neuron address width (fan-in × input precision).
- `OUT_BITS`, 2: per-neuron output width.
- `NID_W`, `$clog2(NUM_NEURONS)` (min 1): neuron-select width.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: input beat valid.
- `s_ready` out 1: input beat accepted when `s_valid && s_ready`.
- `s_data` in `NUM_NEURONS*IN_BITS`: neuron n address at `[n*IN_BITS +: IN_BITS]`.
- `m_valid` out 1: output beat valid.
- `m_ready` in 1: downstream accept.
- `m_data` out `NUM_NEURONS*OUT_BITS`: neuron n result at `[n*OUT_BITS +: OUT_BITS]`.
- `cfg_valid` in 1: table-write beat valid.
- `cfg_ready` out 1: table-write accepted.
- `cfg_nid` in `NID_W`: target neuron.
- `cfg_addr` in `IN_BITS`: table entry.
- `cfg_data` in `OUT_BITS`: entry value.
- `cfg_last` in 1: final beat of a programming burst.
- `busy` out 1: high whenever state ≠ RUN.

## Operation
- Storage: `NUM_NEURONS × 2^IN_BITS × OUT_BITS` registers, distributed-ROM style. All entries reset to 0.
- FSM states:
  - RUN (reset state).
  - DRAIN.
  - PROG.
- RUN:
  - Streams lookups.
  - `cfg_valid=1` moves to DRAIN next cycle.
  - `s_ready` is forced 0 in any cycle where `cfg_valid=1`. Configuration has priority on simultaneous requests.
- DRAIN:
  - `s_ready=0`.
  - The pipeline continues to empty into `m_*`.
  - Moves to PROG when both stage valids are 0.
- PROG:
  - `cfg_ready=1`, `s_ready=0`.
  - Each accepted beat writes `table[cfg_nid][cfg_addr] <= cfg_data`.
  - Accepted beat with `cfg_last=1` returns to RUN next cycle.
  - `cfg_nid ≥ NUM_NEURONS`: the beat is accepted and discarded, with no write.
- `cfg_ready=0` in RUN and DRAIN.
- Pipeline:
  - Stage 1 registers `s_data`.
  - Stage 2 registers all `NUM_NEURONS` table reads into `m_data`.
  - The pipeline advances when `!m_valid || m_ready`. Otherwise both stages hold.
  - `s_ready = (state==RUN) && !cfg_valid && (!s1_valid || advance)`.
- Reset mid-burst or mid-stream: all tables are cleared and the FSM returns to RUN. Any partially loaded table is lost and must be reprogrammed.

## Timing
- Reset values:
  - `s_ready=1`, `m_valid=0`, `m_data=0`.
  - `cfg_ready=0`, `busy=0`.
- Lookup latency: 2 cycles from accepted input to `m_valid`.
- Throughput: 1 beat/cycle with `m_ready` held high.
- `m_data` is stable while `m_valid && !m_ready`.
- A table write in PROG cycle t is visible to the first lookup accepted after the return to RUN. No lookup ever observes a half-written burst.
- RUN→DRAIN→PROG with an empty pipeline and no backpressure: `cfg_ready` rises 2 cycles after `cfg_valid`.
- `busy` is registered and follows the state.

## Configuration
- `LUT_READBACK_EN`.
  - Defined: adds ports `rb_valid` in 1, `rb_nid` in `NID_W`, `rb_addr` in `IN_BITS`, `rb_data` out `OUT_BITS`, `rb_data_valid` out 1.
    - Readback is honoured only in PROG.
    - `rb_data` returns 1 cycle after `rb_valid`; reset value 0.
    - `rb_valid` outside PROG is ignored (`rb_data_valid=0`).
  - Undefined: the ports are absent and no readback mux is generated.

## Structure
- Package `logicnets_pkg`:
  - FSM enum `lut_state_t {RUN, DRAIN, PROG}`.
  - Default-width localparams.
  - A helper function for address slicing.
- One sub-module, `logicnets_lut_neuron`: one neuron's table, with write port and registered read. It is instantiated `NUM_NEURONS` times via generate.

## Test plan
- Reset, then lookup `s_data` = all neurons 7'b1100000 -> after 2 cycles `m_valid=1`, `m_data` all 0.
- Program neuron 0 addr 7'b1100000 = 2'b01 and neuron 1 addr 7'b0110000 = 2'b11 (last on second beat) -> lookup {n1=7'b0110000, n0=7'b1100000} returns n0=01, n1=11, others 00.
- 8 back-to-back inputs with `m_ready=1` -> 8 outputs on consecutive cycles in order. With `m_ready` low for 3 cycles -> stall, `m_data` stable, no loss or duplication.
- `cfg_valid` and `s_valid` asserted in the same RUN cycle with 2 beats in flight -> `s_ready=0`, both in-flight beats delivered, `cfg_ready` rises only after the pipeline is empty.
- `rst_n` pulsed low after 3 of 5 cfg beats -> `busy=0` and all lookups return 0.
- With `LUT_READBACK_EN` defined: write n2 addr 5 = 2'b10, then `rb_valid` n2 addr 5 -> `rb_data=2'b10` with `rb_data_valid=1` one cycle later.

Source files
------------

// File: rtl/logicnets_pkg.sv
// Shared types and defaults for the runtime-programmable LogicNets LUT layer.
// Optional readback port is enabled with LUT_READBACK_EN.
package logicnets_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    PROG  = 2'd2
  } lut_state_t;

  localparam int DEF_NUM_NEURONS = 4;
  localparam int DEF_IN_BITS     = 7;
  localparam int DEF_OUT_BITS    = 2;

  // Low bit of lane `lane` in a flat vector of `width`-bit lanes.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/logicnets_lut_neuron.sv
// One neuron's truth table: synchronous write port, registered lookup read.
// With LUT_READBACK_EN an extra combinational read port serves table readback.
module logicnets_lut_neuron #(
  parameter int IN_BITS  = 7,
  parameter int OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [IN_BITS-1:0]  waddr,
  input  logic [OUT_BITS-1:0] wdata,
  input  logic                re,
  input  logic [IN_BITS-1:0]  raddr,
`ifdef LUT_READBACK_EN
  input  logic [IN_BITS-1:0]  rb_addr,
  output logic [OUT_BITS-1:0] rb_q,
`endif
  output logic [OUT_BITS-1:0] rdata
);

  localparam int DEPTH = 1 << IN_BITS;

  logic [OUT_BITS-1:0] mem [DEPTH];

  // Every entry is a flop so the whole table clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
    end
  end

`ifdef LUT_READBACK_EN
  assign rb_q = mem[rb_addr];
`endif

endmodule

// File: rtl/logicnets_lut_layer.sv
// Pipelined, runtime-programmable LogicNets layer of NUM_NEURONS truth-table neurons.
// Define LUT_READBACK_EN to add the PROG-only table readback port.
module logicnets_lut_layer
  import logicnets_pkg::*;
#(
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int IN_BITS     = DEF_IN_BITS,
  parameter int OUT_BITS    = DEF_OUT_BITS,
  parameter int NID_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [NUM_NEURONS*IN_BITS-1:0]  s_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] m_data,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [NID_W-1:0]                cfg_nid,
  input  logic [IN_BITS-1:0]              cfg_addr,
  input  logic [OUT_BITS-1:0]             cfg_data,
  input  logic                            cfg_last,
`ifdef LUT_READBACK_EN
  input  logic                            rb_valid,
  input  logic [NID_W-1:0]                rb_nid,
  input  logic [IN_BITS-1:0]              rb_addr,
  output logic [OUT_BITS-1:0]             rb_data,
  output logic                            rb_data_valid,
`endif
  output lut_state_t                      dbg_state,
  output logic                            busy
);

  // Handshake rule on all three streams (s_*, m_*, cfg_*): a beat transfers on a
  // rising edge where valid && ready; valid must not depend on ready.

  lut_state_t state, state_nxt;

  logic                           s1_valid;
  logic [NUM_NEURONS*IN_BITS-1:0] s1_data;
  logic                           advance;
  logic                           s1_en;
  logic                           s_fire;
  logic                           cfg_fire;

  assign advance   = !m_valid || m_ready;
  assign s1_en     = !s1_valid || advance;
  assign s_ready   = (state == RUN) && !cfg_valid && s1_en;
  assign s_fire    = s_valid && s_ready;
  assign cfg_ready = (state == PROG);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (cfg_valid) state_nxt = DRAIN;
      DRAIN:   if (!s1_valid && !m_valid) state_nxt = PROG;
      PROG:    if (cfg_fire && cfg_last) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != RUN);
    end
  end

  // Stage 1 can refill whenever it is empty, even while stage 2 is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      m_valid  <= 1'b0;
    end else begin
      if (s1_en) s1_valid <= s_fire;
      if (s_fire) s1_data <= s_data;
      if (advance) m_valid <= s1_valid;
    end
  end

`ifdef LUT_READBACK_EN
  logic [OUT_BITS-1:0] rb_q [NUM_NEURONS];
  logic                rb_take;

  assign rb_take = rb_valid && (state == PROG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_data       <= '0;
      rb_data_valid <= 1'b0;
    end else begin
      rb_data_valid <= rb_take;
      if (rb_take) rb_data <= (int'(rb_nid) < NUM_NEURONS) ? rb_q[rb_nid] : '0;
    end
  end
`endif

  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
    logic we;
    // Beats aimed at a nonexistent neuron match no lane and are dropped.
    assign we = cfg_fire && (cfg_nid == NID_W'(n));

    logicnets_lut_neuron #(
      .IN_BITS  (IN_BITS),
      .OUT_BITS (OUT_BITS)
    ) u_neuron (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (we),
      .waddr   (cfg_addr),
      .wdata   (cfg_data),
      .re      (advance && s1_valid),
      .raddr   (s1_data[lane_lo(n, IN_BITS) +: IN_BITS]),
`ifdef LUT_READBACK_EN
      .rb_addr (rb_addr),
      .rb_q    (rb_q[n]),
`endif
      .rdata   (m_data[lane_lo(n, OUT_BITS) +: OUT_BITS])
    );
  end

endmodule

// File: tb/tb_logicnets_lut_layer.sv
// Directed self-checking bench for logicnets_lut_layer (default 4x7->2 configuration).
// Readback steps are included when LUT_READBACK_EN is defined.
module tb_logicnets_lut_layer;
  import logicnets_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [27:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_nid;
  logic [6:0]  cfg_addr;
  logic [1:0]  cfg_data;
  logic        cfg_last;
  lut_state_t  dbg_state;
  logic        busy;
`ifdef LUT_READBACK_EN
  logic        rb_valid;
  logic [1:0]  rb_nid;
  logic [6:0]  rb_addr;
  logic [1:0]  rb_data;
  logic        rb_data_valid;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];

  logicnets_lut_layer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_nid       (cfg_nid),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .cfg_last      (cfg_last),
`ifdef LUT_READBACK_EN
    .rb_valid      (rb_valid),
    .rb_nid        (rb_nid),
    .rb_addr       (rb_addr),
    .rb_data       (rb_data),
    .rb_data_valid (rb_data_valid),
`endif
    .dbg_state     (dbg_state),
    .busy          (busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] pack_in(input logic [6:0] a3, input logic [6:0] a2,
                                          input logic [6:0] a1, input logic [6:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic set_cfg(input logic v, input logic [1:0] nid, input logic [6:0] addr,
                         input logic [1:0] data, input logic last);
    cfg_valid = v;
    cfg_nid   = nid;
    cfg_addr  = addr;
    cfg_data  = data;
    cfg_last  = last;
  endtask

  // Single isolated lookup: accept, stage 1, then result visible with m_valid.
  task automatic lookup(input string tag, input logic [27:0] d, input logic [7:0] exp);
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = d;
    #1;
    check({tag, "_s_ready"}, s_ready, 1);
    step();
    s_valid = 1'b0;
    check({tag, "_m_valid_early"}, m_valid, 0);
    step();
    check({tag, "_m_valid"}, m_valid, 1);
    check({tag, "_m_data"}, m_data, exp);
    step();
    check({tag, "_m_valid_after"}, m_valid, 0);
  endtask

  // Streaming test patterns: n3 addr j carries j[1:0]; n1/n0 addrs hit programmed entries.
  function automatic logic [27:0] bb_in(input int j);
    logic [6:0] a3;
    a3 = 7'(j);
    return pack_in(a3, 7'h00, 7'h00, (j % 2 == 1) ? 7'h60 : 7'h00);
  endfunction

  function automatic logic [7:0] bb_exp(input int j);
    logic [1:0] v3;
    v3 = 2'(j);
    return {v3, 2'b00, 2'b00, (j % 2 == 1) ? 2'b01 : 2'b00};
  endfunction

  function automatic logic [27:0] st_in(input int k);
    logic [6:0] a3;
    a3 = 7'(k + 3);
    return pack_in(a3, 7'h00, (k % 2 == 0) ? 7'h30 : 7'h00, (k % 2 == 1) ? 7'h60 : 7'h00);
  endfunction

  function automatic logic [7:0] st_exp(input int k);
    logic [1:0] v3;
    v3 = 2'(k + 3);
    return {v3, 2'b00, (k % 2 == 0) ? 2'b11 : 2'b00, (k % 2 == 1) ? 2'b01 : 2'b00};
  endfunction

  initial begin
    int idx;
    int n_out;
    logic hold_prev;
    logic [7:0] held;

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    set_cfg(1'b0, 2'd0, 7'd0, 2'd0, 1'b0);
`ifdef LUT_READBACK_EN
    rb_valid = 1'b0;
    rb_nid   = '0;
    rb_addr  = '0;
`endif

    // Reset values
    step();
    step();
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, RUN);
    rst_n = 1'b1;
    step();

    // Lookup on an empty table returns zeros
    lookup("empty", pack_in(7'h60, 7'h60, 7'h60, 7'h60), 8'h00);

    // Two-beat programming burst, with RUN->DRAIN->PROG timing
    set_cfg(1'b1, 2'd0, 7'h60, 2'b01, 1'b0);
    s_valid = 1'b1;
    s_data  = pack_in(7'h0, 7'h0, 7'h0, 7'h0);
    #1;
    check("prio_s_ready", s_ready, 0);
    check("run_cfg_ready", cfg_ready, 0);
    s_valid = 1'b0;
    step();
    check("drain_busy", busy, 1);
    check("drain_cfg_ready", cfg_ready, 0);
    check("drain_state", dbg_state, DRAIN);
    step();
    check("prog_cfg_ready", cfg_ready, 1);
    check("prog_s_ready", s_ready, 0);
    step();
    set_cfg(1'b1, 2'd1, 7'h30, 2'b11, 1'b1);
    step();
    set_cfg(1'b0, 2'd0, 7'd0, 2'd0, 1'b0);
    #1;
    check("back_busy", busy, 0);
    check("back_cfg_ready", cfg_ready, 0);
    check("back_state", dbg_state, RUN);
    lookup("prog2", pack_in(7'h00, 7'h00, 7'h30, 7'h60), 8'h0D);

    // Burst: neuron 3 addr i <= i[1:0] for i = 0..7
    set_cfg(1'b1, 2'd3, 7'd0, 2'd0, 1'b0);
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      set_cfg(1'b1, 2'd3, 7'(i), 2'(i), (i == 7));
      step();
    end
    set_cfg(1'b0, 2'd0, 7'd0, 2'd0, 1'b0);
    #1;
    check("burst_busy", busy, 0);

    // Eight back-to-back lookups at full rate
    for (int j = 0; j < 10; j++) begin
      m_ready = 1'b1;
      s_valid = (j < 8);
      s_data  = bb_in(j);
      #1;
      if (j < 8) check($sformatf("bb_s_ready_%0d", j), s_ready, 1);
      step();
      check($sformatf("bb_m_valid_%0d", j), m_valid, (j >= 1 && j <= 8));
      if (j >= 1 && j <= 8) check($sformatf("bb_m_data_%0d", j - 1), m_data, bb_exp(j - 1));
    end
    s_valid = 1'b0;

    // Backpressure: m_ready low for 3 cycles while 5 beats stream through
    idx = 0;
    n_out = 0;
    hold_prev = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      m_ready = !(cyc >= 2 && cyc <= 4);
      s_valid = (idx < 5);
      s_data  = st_in(idx);
      #1;
      if (hold_prev) begin
        check($sformatf("stall_valid_%0d", cyc), m_valid, 1);
        check($sformatf("stall_data_%0d", cyc), m_data, held);
      end
      if (m_valid && m_ready) begin
        check($sformatf("sb_nonempty_%0d", cyc), exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check($sformatf("sb_data_%0d", n_out), m_data, exp_q.pop_front());
        n_out++;
      end
      hold_prev = m_valid && !m_ready;
      held = m_data;
      if (s_valid && s_ready) begin
        exp_q.push_back(st_exp(idx));
        idx++;
      end
      step();
    end
    s_valid = 1'b0;
    check("stall_out_count", n_out, 5);
    check("stall_q_empty", exp_q.size(), 0);
    check("stall_in_count", idx, 5);

    // Config and input together with two beats in flight
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = pack_in(7'h00, 7'h00, 7'h00, 7'h60);
    step();
    s_data  = pack_in(7'h00, 7'h00, 7'h30, 7'h00);
    step();
    s_data  = pack_in(7'h01, 7'h00, 7'h00, 7'h00);
    set_cfg(1'b1, 2'd0, 7'h00, 2'b10, 1'b1);
    #1;
    check("coll_s_ready", s_ready, 0);
    check("coll_m_valid_a", m_valid, 1);
    check("coll_m_data_a", m_data, 8'h01);
    step();
    check("coll_busy", busy, 1);
    check("coll_s_ready_drain", s_ready, 0);
    check("coll_m_valid_b", m_valid, 1);
    check("coll_m_data_b", m_data, 8'h0C);
    check("coll_cfg_ready_1", cfg_ready, 0);
    s_valid = 1'b0;
    step();
    check("coll_m_valid_end", m_valid, 0);
    check("coll_cfg_ready_2", cfg_ready, 0);
    step();
    check("coll_cfg_ready_3", cfg_ready, 1);
    step();
    set_cfg(1'b0, 2'd0, 7'd0, 2'd0, 1'b0);
    #1;
    check("coll_busy_end", busy, 0);
    lookup("coll_new", pack_in(7'h00, 7'h00, 7'h00, 7'h00), 8'h02);

`ifdef LUT_READBACK_EN
    // Readback only in PROG, one cycle latency
    set_cfg(1'b1, 2'd2, 7'd5, 2'b10, 1'b0);
    step();
    step();
    step();
    set_cfg(1'b0, 2'd0, 7'd0, 2'd0, 1'b0);
    rb_valid = 1'b1;
    rb_nid   = 2'd2;
    rb_addr  = 7'd5;
    step();
    rb_valid = 1'b0;
    check("rb_data", rb_data, 2'b10);
    check("rb_data_valid", rb_data_valid, 1);
    step();
    check("rb_data_valid_drop", rb_data_valid, 0);
    set_cfg(1'b1, 2'd2, 7'd5, 2'b10, 1'b1);
    step();
    set_cfg(1'b0, 2'd0, 7'd0, 2'd0, 1'b0);
    rb_valid = 1'b1;
    step();
    rb_valid = 1'b0;
    check("rb_run_ignored", rb_data_valid, 0);
    lookup("rb_lookup", pack_in(7'h00, 7'd5, 7'h00, 7'h00), 8'h20);
`endif

    // Reset after 3 of 5 cfg beats clears every table
    set_cfg(1'b1, 2'd0, 7'h11, 2'b11, 1'b0);
    step();
    step();
    step();
    set_cfg(1'b1, 2'd1, 7'h22, 2'b11, 1'b0);
    step();
    set_cfg(1'b1, 2'd2, 7'h33, 2'b11, 1'b0);
    step();
    rst_n = 1'b0;
    set_cfg(1'b0, 2'd0, 7'd0, 2'd0, 1'b0);
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cfg_ready", cfg_ready, 0);
    check("mid_rst_state", dbg_state, RUN);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_busy", busy, 0);
    lookup("post_rst_a", pack_in(7'd7, 7'h33, 7'h22, 7'h11), 8'h00);
    lookup("post_rst_b", pack_in(7'd5, 7'h00, 7'h30, 7'h60), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
